// File: rtl/pipe_chain.sv
// Elastic chain of STAGES valid/ready slots, each with a skid entry: STAGES-cycle latency, 1 word/cycle.
// Backpressure: in_ready is a registered !skid_valid of stage 0, so there is no combinational ready path through the chain.
module pipe_chain #(
    parameter int DATA_W = 64,
    parameter int STAGES = 4,
    parameter int CNT_W  = 16,
    localparam int OCC_W = $clog2(2*STAGES+1)
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic [STAGES-1:0] flush,
    output logic [OCC_W-1:0]  occupancy,
    output logic [CNT_W-1:0]  flush_drops
);
    localparam int SUM_W = ((CNT_W > OCC_W) ? CNT_W : OCC_W) + 1;

    logic [STAGES-1:0] r_mv;
    logic [STAGES-1:0] r_sv;
    logic [DATA_W-1:0] r_md [STAGES];
    logic [DATA_W-1:0] r_sd [STAGES];
    logic [CNT_W-1:0]  r_drops;

    logic [STAGES-1:0] w_up_vld;
    logic [STAGES-1:0] w_dn_rdy;
    logic [STAGES-1:0] w_acc;
    logic [STAGES-1:0] w_take;
    logic [DATA_W-1:0] w_up_dat [STAGES];
    logic [SUM_W-1:0]  w_drop_evt;
    logic [SUM_W-1:0]  w_drop_sum;
    logic [CNT_W-1:0]  w_drops_nxt;
    logic [OCC_W-1:0]  w_occ;

    genvar g;
    for (g = 0; g < STAGES; g++) begin : g_link
        if (g == 0) begin : g_head
            assign w_up_vld[g] = in_valid;
            assign w_up_dat[g] = in_data;
        end else begin : g_body
            assign w_up_vld[g] = r_mv[g-1];
            assign w_up_dat[g] = r_md[g-1];
        end
        if (g == STAGES-1) begin : g_tail
            assign w_dn_rdy[g] = out_ready;
        end else begin : g_next
            assign w_dn_rdy[g] = ~r_sv[g+1];
        end
        assign w_acc[g]  = w_up_vld[g] & ~r_sv[g];
        assign w_take[g] = r_mv[g] & w_dn_rdy[g];
    end

    // A word leaving a flushed stage survives; its skid and any word arriving into it do not.
    always_comb begin
        w_drop_evt = '0;
        for (int i = 0; i < STAGES; i++) begin
            if (flush[i]) begin
                w_drop_evt = w_drop_evt + SUM_W'(r_mv[i] & ~w_take[i])
                                        + SUM_W'(r_sv[i]) + SUM_W'(w_acc[i]);
            end
        end
        w_drop_sum  = SUM_W'(r_drops) + w_drop_evt;
        w_drops_nxt = (w_drop_sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}}
                                                            : w_drop_sum[CNT_W-1:0];
    end

    always_comb begin
        w_occ = '0;
        for (int i = 0; i < STAGES; i++) begin
            w_occ = w_occ + OCC_W'(r_mv[i]) + OCC_W'(r_sv[i]);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_mv    <= '0;
            r_sv    <= '0;
            r_drops <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_md[i] <= '0;
                r_sd[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (flush[i]) begin
                    r_mv[i] <= 1'b0;
                    r_sv[i] <= 1'b0;
                end else if (!r_mv[i] || w_take[i]) begin
                    if (r_sv[i]) begin
                        r_mv[i] <= 1'b1;
                        r_md[i] <= r_sd[i];
                    end else if (w_acc[i]) begin
                        r_mv[i] <= 1'b1;
                        r_md[i] <= w_up_dat[i];
                    end else begin
                        r_mv[i] <= 1'b0;
                    end
                    r_sv[i] <= 1'b0;
                end else if (w_acc[i]) begin
                    r_sv[i] <= 1'b1;
                    r_sd[i] <= w_up_dat[i];
                end
            end
            r_drops <= w_drops_nxt;
        end
    end

    assign in_ready    = ~r_sv[0] & ~sys_rst;
    assign out_valid   = r_mv[STAGES-1];
    assign out_data    = r_md[STAGES-1];
    assign occupancy   = w_occ;
    assign flush_drops = r_drops;

endmodule

// File: tb/tb_pipe_chain.sv
// Bench for pipe_chain: per-stage queue model checked every cycle, plus directed literal scenarios.
module tb_pipe_chain;
    localparam int DW  = 64;
    localparam int NS  = 4;
    localparam int CW  = 4;
    localparam int OW  = $clog2(2*NS+1);
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [NS-1:0] flush = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [OW-1:0] occupancy;
    logic [CW-1:0] flush_drops;

    pipe_chain #(.DATA_W(DW), .STAGES(NS), .CNT_W(CW)) dut (
        .sys_clk    (clk),
        .sys_rst    (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .flush      (flush),
        .occupancy  (occupancy),
        .flush_drops(flush_drops)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int peak = 0;
    int log_c[$];
    logic [DW-1:0] log_d[$];

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Model: each stage is a FIFO of at most two words; oldest word at index 0.
    logic [DW-1:0] m_q [NS][2];
    int            m_n [NS];
    int            m_drops = 0;
    bit            m_acc [NS];
    bit            m_take [NS];
    logic [DW-1:0] m_up [NS];

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            for (int i = 0; i < NS; i++) m_n[i] = 0;
            m_drops = 0;
        end else begin
            for (int i = 0; i < NS; i++) begin
                m_acc[i]  = ((i == 0) ? in_valid : (m_n[i-1] > 0)) && (m_n[i] < 2);
                m_up[i]   = (i == 0) ? in_data : m_q[i-1][0];
                m_take[i] = (m_n[i] > 0) && ((i == NS-1) ? out_ready : (m_n[i+1] < 2));
            end
            for (int i = 0; i < NS; i++) begin
                if (m_take[i]) begin
                    m_q[i][0] = m_q[i][1];
                    m_n[i]    = m_n[i] - 1;
                end
                if (m_acc[i]) begin
                    m_q[i][m_n[i]] = m_up[i];
                    m_n[i]         = m_n[i] + 1;
                end
            end
            for (int i = 0; i < NS; i++) begin
                if (flush[i]) begin
                    m_drops = m_drops + m_n[i];
                    m_n[i]  = 0;
                end
            end
            if (m_drops > SAT) m_drops = SAT;
        end
    end

    int m_occ;
    always @(negedge clk) begin
        m_occ = 0;
        for (int i = 0; i < NS; i++) m_occ = m_occ + m_n[i];
        check("in_ready", in_ready, (!rst && m_n[0] < 2));
        check("out_valid", out_valid, (m_n[NS-1] > 0));
        if (m_n[NS-1] > 0) check("out_data", out_data, m_q[NS-1][0]);
        check("occupancy", occupancy, m_occ);
        check("flush_drops", flush_drops, m_drops);
        if (occupancy > peak) peak = occupancy;
        if (!rst && out_valid && out_ready) begin
            log_d.push_back(out_data);
            log_c.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; flush = '0;
        step(); step();
        check("rst_occupancy", occupancy, 0);
        check("rst_drops", flush_drops, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        log_d.delete(); log_c.delete(); peak = 0;
    endtask

    task automatic fill(input logic [DW-1:0] base, input int cycles, output int n);
        bit was;
        n = 0; in_valid = 1'b1; in_data = base;
        for (int k = 0; k < cycles; k++) begin
            was = in_ready;
            step();
            if (was) begin n++; in_data = base + DW'(n); end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int n, c0;
        do_reset();

        // Stream: back-to-back words, no stalls.
        out_ready = 1'b1;
        c0 = cyc;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1; in_data = 64'h10 + 64'(k);
            check("stream_in_ready", in_ready, 1);
            step();
        end
        in_valid = 1'b0;
        repeat (8) step();
        check("stream_count", log_d.size(), 8);
        for (int k = 0; k < 8 && k < log_d.size(); k++) begin
            check("stream_data", log_d[k], 64'h10 + 64'(k));
            check("stream_gap", log_c[k] - log_c[0], k);
        end
        if (log_c.size() > 0) check("stream_latency", log_c[0] - c0, 4);
        check("stream_peak", peak, 4);

        // Backpressure: chain fills to 2*STAGES, then drains in order.
        do_reset();
        out_ready = 1'b0;
        fill(64'h20, 12, n);
        check("bp_accepted", n, 8);
        check("bp_in_ready", in_ready, 0);
        check("bp_occupancy", occupancy, 8);
        out_ready = 1'b1;
        repeat (12) step();
        check("bp_count", log_d.size(), 8);
        for (int k = 0; k < 8 && k < log_d.size(); k++) check("bp_data", log_d[k], 64'h20 + 64'(k));

        // Partial flush of a full chain: stages 0/1 hold 0x34..0x37, stages 2/3 hold 0x30..0x33.
        do_reset();
        out_ready = 1'b0;
        fill(64'h30, 12, n);
        flush = 4'b0011;
        step();
        flush = '0;
        check("pf_occupancy", occupancy, 4);
        check("pf_drops", flush_drops, 4);
        out_ready = 1'b1;
        repeat (10) step();
        check("pf_count", log_d.size(), 4);
        for (int k = 0; k < 4 && k < log_d.size(); k++) check("pf_data", log_d[k], 64'h30 + 64'(k));

        // Flush of stage 0 on the same edge as an accept into it.
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 64'hAA; flush = 4'b0001;
        check("fa_in_ready", in_ready, 1);
        step();
        flush = '0;
        check("fa_drops", flush_drops, 1);
        check("fa_occupancy", occupancy, 0);
        in_data = 64'hBB;
        step();
        in_valid = 1'b0;
        repeat (8) step();
        check("fa_count", log_d.size(), 1);
        if (log_d.size() > 0) check("fa_data", log_d[0], 64'hBB);

        // Saturation of the 4-bit drop counter.
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_valid = 1'b1; in_data = 64'h100 + 64'(k); flush = 4'b0001;
            step();
            check("sat_drops", flush_drops, (k + 1 > 15) ? 15 : k + 1);
        end
        flush = '0; in_valid = 1'b0;
        repeat (3) step();
        check("sat_hold", flush_drops, 15);

        // Reset mid-operation with 6 resident words and 3 drops.
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = 64'hE0 + 64'(k); flush = 4'b0001;
            step();
        end
        flush = '0;
        out_ready = 1'b0;
        fill(64'h40, 6, n);
        check("rm_accepted", n, 6);
        check("rm_occupancy", occupancy, 6);
        check("rm_drops", flush_drops, 3);
        rst = 1'b1;
        step();
        check("rm_out_valid", out_valid, 0);
        check("rm_occ_rst", occupancy, 0);
        check("rm_drops_rst", flush_drops, 0);
        check("rm_in_ready", in_ready, 0);
        step();
        rst = 1'b0; out_ready = 1'b1;
        #1;
        log_d.delete(); log_c.delete();
        in_valid = 1'b1; in_data = 64'h55; c0 = cyc;
        check("rm_ready_after", in_ready, 1);
        step();
        in_valid = 1'b0;
        repeat (6) step();
        check("rm_count", log_d.size(), 1);
        if (log_d.size() > 0) begin
            check("rm_data", log_d[0], 64'h55);
            check("rm_latency", log_c[0] - c0, 4);
        end

        // Randomized traffic with sparse flushes and occasional resets.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = {$urandom, $urandom};
            out_ready = ((k / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            for (int b = 0; b < NS; b++) flush[b] = ($urandom_range(0, 31) == 0);
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0; flush = '0; in_valid = 1'b0;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
